// File: rtl/cga_tty_writer.sv
`default_nettype none
// ============================================================================
// Module   : cga_tty_writer
// Brief    : Byte-stream console writer driving the CGA text memory write port
//            (print, CR/LF/BS/FF, wrap, scroll-up, clear-screen).
// Revision : 1.0 - initial release
// ============================================================================
module cga_tty_writer #(
    parameter int         COLS = 80,
    parameter int         ROWS = 25,
    parameter logic [7:0] ATTR = 8'h07
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [12:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_q,
    output logic [6:0]  cursor_x,
    output logic [4:0]  cursor_y,
    output logic        busy
);

    localparam logic [6:0]  c_X_MAX       = 7'(COLS - 1);
    localparam logic [4:0]  c_Y_MAX       = 5'(ROWS - 1);
    localparam logic [12:0] c_ROW_BYTES   = 13'(COLS * 2);
    localparam logic [12:0] c_SCROLL_LAST = 13'((ROWS - 1) * COLS * 2 - 1);
    localparam logic [12:0] c_LAST        = 13'(ROWS * COLS * 2 - 1);
    localparam logic [7:0]  c_BLANK       = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUT_CH  = 3'd1,
        ST_PUT_AT  = 3'd2,
        ST_S_RD    = 3'd3,
        ST_S_WR    = 3'd4,
        ST_CLR_ROW = 3'd5,
        ST_CLEAR   = 3'd6
    } state_t;

    state_t      state_q;
    logic [12:0] addr_q;
    logic [7:0]  wdata_q;
    logic        we_q;
    logic        fwd_q;
    logic        ready_q;
    logic        busy_q;
    logic [6:0]  x_q;
    logic [4:0]  y_q;
    logic [12:0] cell_addr;

    // y * (COLS*2) as a sum of shifted copies of y, one per set bit of the row pitch.
    function automatic logic [12:0] row_base(input logic [4:0] y);
        logic [12:0] acc;
        acc = '0;
        for (int k = 0; k < 13; k++) begin
            if (c_ROW_BYTES[k]) acc = acc + (13'(y) << k);
        end
        return acc;
    endfunction

    assign cell_addr = row_base(y_q) + {5'd0, x_q, 1'b0};

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            fwd_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && ready_q) begin
                        case (in_data)
                            8'h0D: x_q <= '0;
                            8'h0A: begin
                                if (y_q != c_Y_MAX) begin
                                    y_q <= y_q + 5'd1;
                                end else begin
                                    state_q <= ST_S_RD;
                                    addr_q  <= c_ROW_BYTES;
                                    ready_q <= 1'b0;
                                    busy_q  <= 1'b1;
                                end
                            end
                            8'h08: begin
                                if (x_q != 7'd0) x_q <= x_q - 7'd1;
                            end
                            8'h0C: begin
                                state_q <= ST_CLEAR;
                                addr_q  <= '0;
                                wdata_q <= c_BLANK;
                                we_q    <= 1'b1;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b1;
                            end
                            default: begin
                                state_q <= ST_PUT_CH;
                                addr_q  <= cell_addr;
                                wdata_q <= in_data;
                                we_q    <= 1'b1;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_PUT_CH: begin
                    state_q <= ST_PUT_AT;
                    addr_q  <= addr_q + 13'd1;
                    wdata_q <= ATTR;
                end
                ST_PUT_AT: begin
                    we_q <= 1'b0;
                    if (x_q == c_X_MAX) begin
                        x_q <= '0;
                        if (y_q == c_Y_MAX) begin
                            state_q <= ST_S_RD;
                            addr_q  <= c_ROW_BYTES;
                        end else begin
                            y_q     <= y_q + 5'd1;
                            state_q <= ST_IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        x_q     <= x_q + 7'd1;
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                // The address register doubles as the scroll counter: read at i+pitch, write at i.
                ST_S_RD: begin
                    state_q <= ST_S_WR;
                    addr_q  <= addr_q - c_ROW_BYTES;
                    we_q    <= 1'b1;
                    fwd_q   <= 1'b1;
                end
                ST_S_WR: begin
                    fwd_q <= 1'b0;
                    if (addr_q == c_SCROLL_LAST) begin
                        state_q <= ST_CLR_ROW;
                        addr_q  <= addr_q + 13'd1;
                        wdata_q <= c_BLANK;
                    end else begin
                        state_q <= ST_S_RD;
                        addr_q  <= addr_q + c_ROW_BYTES + 13'd1;
                        we_q    <= 1'b0;
                    end
                end
                ST_CLR_ROW, ST_CLEAR: begin
                    if (addr_q == c_LAST) begin
                        if (state_q == ST_CLEAR) begin
                            x_q <= '0;
                            y_q <= '0;
                        end
                        state_q <= ST_IDLE;
                        we_q    <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        addr_q  <= addr_q + 13'd1;
                        wdata_q <= addr_q[0] ? c_BLANK : ATTR;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    we_q    <= 1'b0;
                    fwd_q   <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Scroll data arrives from memory during the write cycle itself, so it is forwarded.
    assign mem_wdata   = fwd_q ? mem_q : wdata_q;
    assign mem_address = addr_q;
    assign mem_we      = we_q;
    assign in_ready    = ready_q;
    assign busy        = busy_q;
    assign cursor_x    = x_q;
    assign cursor_y    = y_q;

endmodule
`default_nettype wire
